lb_uart_rx_control_unit: RTL and testbench

Control unit for the UART receive path. It oversamples the serial input at 16× the baud rate, detects and qualifies the start bit, and steps through the data, optional parity and stop bits. For each bit it issues one sample strobe at mid-bit to the Rx datapath shift register. Frame length is configured by `bit8`/`parity_en`, and bit timing by the same 20-bit `baudPrescale` used on the Tx side.

---
 rtl/lb_uart_rx_control_unit_pkg.sv | 25 ++
 rtl/lb_rx_tick_gen.sv | 44 ++++
 rtl/lb_uart_rx_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_lb_uart_rx_control_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_uart_rx_control_unit_pkg.sv
// Shared constants for the UART receive control unit.
//  - FSM state encodings (3-bit, legacy-compatible localparams)
//  - oversampling ratio and mid-bit sample point
//  - helper returning the index of the last data bit for a frame format
package lb_uart_rx_control_unit_pkg;

    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_START  = 3'd1;
    localparam logic [2:0] STATE_DATA   = 3'd2;
    localparam logic [2:0] STATE_PARITY = 3'd3;
    localparam logic [2:0] STATE_STOP   = 3'd4;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Oversample counter values at which the FSM acts (counter counts ticks
    // already seen in the current state, so the Nth tick sees N-1).
    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_MID  = 4'(MID_SAMPLE - 1);

    function automatic logic [2:0] last_bit_idx(input logic bit8);
        return bit8 ? 3'd7 : 3'd6;
    endfunction

endpackage

// File: rtl/lb_rx_tick_gen.sv
// Oversample tick generator for the UART receiver.
//  clk, rst_n : clock, asynchronous active-low reset
//  cs         : enable; 0 freezes the counter and suppresses ticks
//  hold       : keep the counter at 0 (receiver idle) so the tick phase
//               is aligned to the detected start edge
//  prescale   : tick period minus one, in clk cycles
//  tick       : one-cycle strobe every prescale+1 enabled cycles
module lb_rx_tick_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        hold,
    input  logic [19:0] prescale,
    output logic        tick
);

    logic [19:0] cnt_q;
    logic [19:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (cs) begin
            if (hold) begin
                cnt_d = '0;
            end else if (cnt_q >= prescale) begin
                // >= keeps the counter bounded if prescale ever shrinks.
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lb_uart_rx_control_unit.sv
// UART receive control unit.
// Oversamples rx at 16x baud, qualifies the start bit at mid-bit, then
// steps through data, optional parity and stop bits, issuing one strobe
// per bit at mid-bit for the Rx datapath.
// Ports:
//  clk, reset      : clock, asynchronous active-low reset
//  rx              : asynchronous serial line, idle high
//  bit8, parity_en : frame format (8/7 data bits, parity bit present)
//  baudPrescale    : oversample tick period minus one
//  cs              : enable; 0 freezes all counters and the FSM
//  rx_bit          : synchronized rx for the datapath shift-in
//  shift           : pulse, shift rx_bit in as a data bit
//  parity_sample   : pulse, capture rx_bit as received parity
//  done            : pulse, frame complete
//  frame_err       : stop bit was low; updated with done, held otherwise
//  busy            : start detected and frame not yet done
//  dbg_state       : current FSM state (debug)
// Strobe semantics: shift, parity_sample and done are single-cycle,
// registered pulses; the datapath acts on the clock edge at which the
// pulse is high and uses rx_bit from the same cycle. There is no
// backpressure.
module lb_uart_rx_control_unit
    import lb_uart_rx_control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        bit8,
    input  logic        parity_en,
    input  logic [19:0] baudPrescale,
    input  logic        cs,
    output logic        rx_bit,
    output logic        shift,
    output logic        parity_sample,
    output logic        done,
    output logic        frame_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    logic       sync1_q;
    logic       sync2_q;
    logic [2:0] state_q, state_d;
    logic [3:0] os_q, os_d;
    logic [2:0] bit_q, bit_d;
    logic       shift_q, shift_d;
    logic       parity_q, parity_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       tick;

    lb_rx_tick_gen u_tick_gen (
        .clk      (clk),
        .rst_n    (reset),
        .cs       (cs),
        .hold     (state_q == STATE_IDLE),
        .prescale (baudPrescale),
        .tick     (tick)
    );

    // Synchronizer runs regardless of cs; resets to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        os_d     = os_q;
        bit_d    = bit_q;
        shift_d  = 1'b0;
        parity_d = 1'b0;
        done_d   = 1'b0;
        ferr_d   = ferr_q;
        busy_d   = busy_q;
        if (cs) begin
            case (state_q)
                STATE_IDLE: begin
                    // Level-sensitive: a line already low right after done
                    // starts the next frame immediately.
                    if (!sync2_q) begin
                        state_d = STATE_START;
                        busy_d  = 1'b1;
                        os_d    = '0;
                        bit_d   = '0;
                    end
                end
                STATE_START: begin
                    if (tick) begin
                        if (os_q == OS_MID) begin
                            os_d = '0;
                            if (sync2_q) begin
                                state_d = STATE_IDLE;   // false start
                                busy_d  = 1'b0;
                            end else begin
                                state_d = STATE_DATA;
                            end
                        end else begin
                            os_d = os_q + 4'd1;
                        end
                    end
                end
                STATE_DATA: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_d    = '0;
                            shift_d = 1'b1;
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == last_bit_idx(bit8)) begin
                                state_d = parity_en ? STATE_PARITY : STATE_STOP;
                            end
                        end else begin
                            os_d = os_q + 4'd1;
                        end
                    end
                end
                STATE_PARITY: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_d     = '0;
                            parity_d = 1'b1;
                            state_d  = STATE_STOP;
                        end else begin
                            os_d = os_q + 4'd1;
                        end
                    end
                end
                STATE_STOP: begin
                    if (tick) begin
                        if (os_q == OS_LAST) begin
                            os_d    = '0;
                            done_d  = 1'b1;
                            ferr_d  = ~sync2_q;
                            busy_d  = 1'b0;
                            state_d = STATE_IDLE;
                        end else begin
                            os_d = os_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = STATE_IDLE;
                    busy_d  = 1'b0;
                    os_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STATE_IDLE;
            os_q     <= '0;
            bit_q    <= '0;
            shift_q  <= 1'b0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            os_q     <= os_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign rx_bit        = sync2_q;
    assign shift         = shift_q;
    assign parity_sample = parity_q;
    assign done          = done_q;
    assign frame_err     = ferr_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lb_uart_rx_control_unit.sv
// Bench for lb_uart_rx_control_unit: serial frames are generated from a
// bit list, expected strobes are placed at the cycles given by the frame
// timing rules (start, 24 ticks, 16 ticks per bit), and one compare
// process checks every output each cycle against that schedule.
module tb_lb_uart_rx_control_unit;

    localparam int K_SHIFT = 0;
    localparam int K_PAR   = 1;
    localparam int K_DONE  = 2;
    localparam int HOLD_CLKS = 100;

    typedef struct {
        int   cyc;
        int   kind;
        logic val;
    } ev_t;

    typedef struct {
        int from;
        int to;
    } win_t;

    // clock / reset / DUT
    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        bit8;
    logic        parity_en;
    logic [19:0] baudPrescale;
    logic        cs;
    logic        rx_bit;
    logic        shift;
    logic        parity_sample;
    logic        done;
    logic        frame_err;
    logic        busy;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lb_uart_rx_control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .bit8          (bit8),
        .parity_en     (parity_en),
        .baudPrescale  (baudPrescale),
        .cs            (cs),
        .rx_bit        (rx_bit),
        .shift         (shift),
        .parity_sample (parity_sample),
        .done          (done),
        .frame_err     (frame_err),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // scoreboard state
    ev_t  exp_q[$];
    win_t busy_q[$];
    logic chk_en = 1'b0;
    logic exp_ferr = 1'b0;
    logic prev_busy = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // observations used by the literal pin checks
    int   obs_shift[$];
    logic obs_bits[$];
    int   obs_par = 0;
    int   obs_done = 0;
    int   obs_rise = 0;
    int   obs_fall = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic obs_clear();
        obs_shift.delete();
        obs_bits.delete();
        obs_par = 0;
        obs_done = 0;
        obs_rise = 0;
        obs_fall = 0;
    endtask

    function automatic int obs_word();
        int v = 0;
        for (int i = 0; i < obs_bits.size(); i++) v |= int'(obs_bits[i]) << i;
        return v;
    endfunction

    // compare process
    always @(negedge clk) begin
        logic e_sh;
        logic e_pa;
        logic e_dn;
        logic e_val;
        logic e_busy;
        if (!chk_en) begin
            prev_busy = 1'b0;
            exp_ferr  = 1'b0;
        end else begin
            e_sh = 1'b0; e_pa = 1'b0; e_dn = 1'b0; e_val = 1'b0;
            while (busy_q.size() > 0 && cyc >= busy_q[0].to) void'(busy_q.pop_front());
            e_busy = (busy_q.size() > 0 && cyc >= busy_q[0].from);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("event_schedule", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e_sh  = (exp_q[0].kind == K_SHIFT);
                e_pa  = (exp_q[0].kind == K_PAR);
                e_dn  = (exp_q[0].kind == K_DONE);
                e_val = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            if (e_dn) exp_ferr = e_val;
            chk("shift", int'(shift), int'(e_sh));
            chk("parity_sample", int'(parity_sample), int'(e_pa));
            chk("done", int'(done), int'(e_dn));
            chk("frame_err", int'(frame_err), int'(exp_ferr));
            chk("busy", int'(busy), int'(e_busy));
            if (e_sh || e_pa) chk("rx_bit_at_strobe", int'(rx_bit), int'(e_val));
            if (shift) begin
                obs_shift.push_back(cyc);
                obs_bits.push_back(rx_bit);
            end
            if (parity_sample) obs_par++;
            if (done) obs_done = cyc;
            if (busy && !prev_busy) obs_rise = cyc;
            if (!busy && prev_busy) obs_fall = cyc;
            prev_busy = busy;
        end
    end

    // driver helpers
    function automatic logic line_level(input int t, input int tk, input int n,
                                        input logic [7:0] data, input bit pe,
                                        input bit pv, input bit stop_ok);
        int bt = 16 * tk;
        int j  = t / bt;
        int m  = n + int'(pe) + 1;
        if (j == 0) return 1'b0;
        if (j <= n) return data[j-1];
        if (pe && j == n + 1) return pv;
        if (j > m || stop_ok) return 1'b1;
        // A low stop bit is released just early enough that the idle line
        // is seen again right after done.
        return ((t - bt * m) < 8 * tk + 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic push_ev(input int c, input int kind, input logic v, input int h);
        ev_t e;
        e.cyc  = (c >= h + 1) ? c + HOLD_CLKS : c;
        e.kind = kind;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        chk_en = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        busy_q.delete();
        #1;
        chk("rst_rx_bit", int'(rx_bit), 1);
        chk("rst_shift", int'(shift), 0);
        chk("rst_parity_sample", int'(parity_sample), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rx = 1'b1;
        cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;
    endtask

    // One frame. hold_at / rst_at are clock offsets from the start edge
    // (negative = not used).
    task automatic send_frame(input logic [7:0] data, input bit b8, input bit pe,
                              input bit pv, input bit stop_ok, input int pre,
                              input int hold_at, input int rst_at);
        int tk = pre + 1;
        int n  = b8 ? 8 : 7;
        int m  = n + int'(pe) + 1;
        int len = 16 * tk * (m + 1);
        int k, e0, h, dn;
        win_t w;
        bit8 = b8;
        parity_en = pe;
        baudPrescale = 20'(pre);
        @(posedge clk);
        #1;
        k  = cyc;
        rx = 1'b0;
        e0 = k + 3;
        h  = (hold_at >= 0) ? k + hold_at : (1 << 30);
        for (int i = 0; i < n; i++) push_ev(e0 + 24 * tk + 16 * tk * i, K_SHIFT, data[i], h);
        if (pe) push_ev(e0 + 24 * tk + 16 * tk * n, K_PAR, pv, h);
        dn = e0 + 8 * tk + 16 * tk * m;
        push_ev(dn, K_DONE, !stop_ok, h);
        w.from = e0;
        w.to   = (dn >= h + 1) ? dn + HOLD_CLKS : dn;
        busy_q.push_back(w);
        for (int t = 1; t < len; t++) begin
            @(posedge clk);
            #1;
            if (t == rst_at) begin
                mid_reset();
                return;
            end
            rx = line_level(t, tk, n, data, pe, pv, stop_ok);
            if (t == hold_at) begin
                cs = 1'b0;
                repeat (HOLD_CLKS) @(posedge clk);
                #1;
                cs = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    // rx low for low_ticks ticks, then high again: must be rejected.
    task automatic glitch(input int pre, input int low_ticks);
        int tk = pre + 1;
        int k;
        win_t w;
        baudPrescale = 20'(pre);
        @(posedge clk);
        #1;
        k  = cyc;
        rx = 1'b0;
        w.from = k + 3;
        w.to   = k + 3 + 8 * tk;
        busy_q.push_back(w);
        for (int t = 1; t <= 8 * tk + 8; t++) begin
            @(posedge clk);
            #1;
            if (t == low_ticks * tk) rx = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] d;
        int pre, tk, m, hold_at, rst_at;
        bit b8, pe, ok;

        rx = 1'b1; cs = 1'b1; bit8 = 1'b1; parity_en = 1'b0; baudPrescale = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_rx_bit", int'(rx_bit), 1);
        chk("init_shift", int'(shift), 0);
        chk("init_parity_sample", int'(parity_sample), 0);
        chk("init_done", int'(done), 0);
        chk("init_frame_err", int'(frame_err), 0);
        chk("init_busy", int'(busy), 0);
        reset = 1'b1;
        chk_en = 1'b1;
        idle(4);

        // 8N1, prescale 0, 0xA5
        obs_clear();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, -1);
        idle(5);
        chk("a5_shift_count", obs_shift.size(), 8);
        chk("a5_first_shift", obs_shift[0] - obs_rise, 24);
        chk("a5_shift_spacing", obs_shift[7] - obs_shift[0], 7 * 16);
        chk("a5_bits", obs_word(), 8'hA5);
        chk("a5_done_after_last", obs_done - obs_shift[7], 16);
        chk("a5_frame_err", int'(frame_err), 0);

        // 7E1, prescale 3, 0x41 with parity 0
        obs_clear();
        send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 3, -1, -1);
        idle(5);
        chk("7e1_shift_count", obs_shift.size(), 7);
        chk("7e1_shift_spacing", obs_shift[1] - obs_shift[0], 64);
        chk("7e1_parity_count", obs_par, 1);
        chk("7e1_frame_clocks", obs_done - obs_rise, 608);
        chk("7e1_bits", obs_word(), 8'h41);

        // glitch: low for 5 ticks at prescale 1
        obs_clear();
        glitch(1, 5);
        idle(3);
        chk("glitch_no_shift", obs_shift.size(), 0);
        chk("glitch_no_done", obs_done, 0);
        chk("glitch_busy_len", obs_fall - obs_rise, 16);

        // low stop bit, then a clean frame clears frame_err
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1, -1, -1);
        idle(2);
        chk("bad_stop_frame_err", int'(frame_err), 1);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 0, -1, -1);
        idle(2);
        chk("good_after_bad_frame_err", int'(frame_err), 0);

        // cs held low 100 clocks inside data bit 3
        obs_clear();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, 16 * 4 + 5, -1);
        idle(5);
        chk("hold_shift_count", obs_shift.size(), 8);
        chk("hold_first_shift", obs_shift[0] - obs_rise, 24);
        chk("hold_frame_clocks", obs_done - obs_rise, 152 + HOLD_CLKS);
        chk("hold_bits", obs_word(), 8'h3C);

        // reset between the 3rd and 4th shift, then a clean frame
        obs_clear();
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, 67);
        chk("rst_shifts_before", obs_shift.size(), 3);
        idle(4);
        obs_clear();
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 0, -1, -1);
        idle(3);
        chk("post_rst_bits", obs_word(), 8'h96);
        chk("post_rst_shift_count", obs_shift.size(), 8);

        // randomized frames
        for (int it = 0; it < 30; it++) begin
            pre = $urandom_range(0, 3);
            tk  = pre + 1;
            if ($urandom_range(0, 9) == 0) begin
                glitch(pre, $urandom_range(1, 6));
            end else begin
                d  = 8'($urandom_range(0, 255));
                b8 = 1'($urandom_range(0, 1));
                pe = 1'($urandom_range(0, 1));
                ok = ($urandom_range(0, 4) != 0);
                m  = (b8 ? 8 : 7) + int'(pe);
                hold_at = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 16 * tk * m) : -1;
                rst_at  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 16 * tk * m) : -1;
                if (!b8) d[7] = 1'b0;
                send_frame(d, b8, pe, 1'($urandom_range(0, 1)), ok, pre, hold_at, rst_at);
            end
            idle($urandom_range(0, 12));
        end

        idle(10);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
